pulse_train_gen: RTL and testbench

Generates a programmable train of clean single-clock-domain pulses on `pulse_out`. It is the source-side counterpart of the positive-edge detector: the detector turns a level into one-cycle edge strobes, and this block turns a one-cycle start strobe into a timed train of rising edges. It is used to drive strobes, enables and test stimulus into downstream logic, including edge detectors in loopback.

---
 rtl/pulse_train_gen_pkg.sv | 18 +
 rtl/pulse_train_gen_if.sv | 29 ++
 rtl/pulse_train_gen_phase_down_counter.sv | 37 +++
 rtl/pulse_train_gen.sv | 156 +++++++++++++++
 tb/tb_pulse_train_gen.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_train_gen_pkg.sv
// Shared types and helpers for the pulse train generator.
// Holds the FSM encoding, default counter width and config zero-substitution.
package pulse_gen_pkg;

   localparam int unsigned CntWDefault = 16;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StHigh = 2'b01,
      StLow  = 2'b10
   } state_e;

   // A zero-length phase would be meaningless, so it is treated as one cycle.
   function automatic logic [31:0] zero_to_one(input logic [31:0] v);
      return (v == 32'd0) ? 32'd1 : v;
   endfunction

endpackage

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle between a pulse train requester and the generator.
// The requester owns start/abort/config; the generator owns the status outputs.
interface pulse_train_gen_if
   import pulse_gen_pkg::*;
#(
   parameter int unsigned CNT_W = CntWDefault
) ();

   logic             start;
   logic             abort;
   logic [CNT_W-1:0] high_cycles;
   logic [CNT_W-1:0] low_cycles;
   logic [CNT_W-1:0] pulse_count;
   logic             pulse_out;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] pulses_sent;

   modport master (
      output start, abort, high_cycles, low_cycles, pulse_count,
      input  pulse_out, busy, done, pulses_sent
   );

   modport slave (
      input  start, abort, high_cycles, low_cycles, pulse_count,
      output pulse_out, busy, done, pulses_sent
   );

endinterface

// File: rtl/pulse_train_gen_phase_down_counter.sv
// Loadable down-counter that stops at zero and flags terminal count.
// Load takes priority over enable.
module phase_down_counter
   import pulse_gen_pkg::*;
#(
   parameter int unsigned CNT_W = CntWDefault
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse train generator: a start strobe yields N pulses of H high
// cycles separated by L low cycles, all outputs driven straight from flops.
module pulse_train_gen
   import pulse_gen_pkg::*;
#(
   parameter int unsigned CNT_W = CntWDefault
) (
   input  logic             clk,
   input  logic             rst_n,
   pulse_train_gen_if.slave bus
);

   state_e           state_q, state_d;
   logic             pulse_out_q, pulse_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] sent_q, sent_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] low_q, low_d;

   logic [CNT_W-1:0] high_in, low_in;
   logic             ph_load, ph_en, ph_tc;
   logic [CNT_W-1:0] ph_load_val;
   logic             rem_load, rem_en, rem_tc;
   logic [CNT_W-1:0] rem_load_val;

   assign high_in = CNT_W'(zero_to_one(32'(bus.high_cycles)));
   assign low_in  = CNT_W'(zero_to_one(32'(bus.low_cycles)));

   always_comb begin
      state_d      = state_q;
      pulse_out_d  = pulse_out_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      sent_d       = sent_q;
      high_d       = high_q;
      low_d        = low_q;
      ph_load      = 1'b0;
      ph_en        = 1'b0;
      ph_load_val  = '0;
      rem_load     = 1'b0;
      rem_en       = 1'b0;
      rem_load_val = '0;

      if (bus.abort) begin
         // pulses_sent is kept so software can see how far the train got.
         state_d     = StIdle;
         pulse_out_d = 1'b0;
         busy_d      = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  high_d = high_in;
                  low_d  = low_in;
                  sent_d = '0;
                  if (bus.pulse_count == '0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d      = StHigh;
                     pulse_out_d  = 1'b1;
                     busy_d       = 1'b1;
                     sent_d       = CNT_W'(1);
                     ph_load      = 1'b1;
                     ph_load_val  = high_in - CNT_W'(1);
                     rem_load     = 1'b1;
                     rem_load_val = bus.pulse_count - CNT_W'(1);
                  end
               end
            end
            StHigh: begin
               if (ph_tc) begin
                  pulse_out_d = 1'b0;
                  if (rem_tc) begin
                     // Last pulse: no trailing low phase.
                     state_d = StIdle;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d     = StLow;
                     ph_load     = 1'b1;
                     ph_load_val = low_q - CNT_W'(1);
                     rem_en      = 1'b1;
                  end
               end else begin
                  ph_en = 1'b1;
               end
            end
            StLow: begin
               if (ph_tc) begin
                  state_d     = StHigh;
                  pulse_out_d = 1'b1;
                  sent_d      = sent_q + CNT_W'(1);
                  ph_load     = 1'b1;
                  ph_load_val = high_q - CNT_W'(1);
               end else begin
                  ph_en = 1'b1;
               end
            end
            default: begin
               state_d     = StIdle;
               pulse_out_d = 1'b0;
               busy_d      = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         pulse_out_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sent_q      <= '0;
         high_q      <= '0;
         low_q       <= '0;
      end else begin
         state_q     <= state_d;
         pulse_out_q <= pulse_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sent_q      <= sent_d;
         high_q      <= high_d;
         low_q       <= low_d;
      end
   end

   phase_down_counter #(
      .CNT_W (CNT_W)
   ) u_phase_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (ph_load),
      .load_val_i (ph_load_val),
      .en_i       (ph_en),
      .tc_o       (ph_tc)
   );

   phase_down_counter #(
      .CNT_W (CNT_W)
   ) u_remain_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (rem_load),
      .load_val_i (rem_load_val),
      .en_i       (rem_en),
      .tc_o       (rem_tc)
   );

   assign bus.pulse_out   = pulse_out_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.pulses_sent = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen with hand-computed cycle masks.
// Cycle k is the interval following the k-th rising edge after a start is launched.
module tb_pulse_train_gen;

   localparam int unsigned CNT_W = 16;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   pulse_train_gen_if #(.CNT_W(CNT_W)) bus ();

   pulse_train_gen #(
      .CNT_W (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Registered rising-edge detector fed by the DUT output.
   logic det_prev, det_strobe;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         det_prev   <= 1'b0;
         det_strobe <= 1'b0;
      end else begin
         det_prev   <= bus.pulse_out;
         det_strobe <= bus.pulse_out & ~det_prev;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic launch(input logic [15:0] h, input logic [15:0] l, input logic [15:0] n);
      bus.high_cycles = h;
      bus.low_cycles  = l;
      bus.pulse_count = n;
      bus.start       = 1'b1;
      tick();
      bus.start       = 1'b0;
   endtask

   // Checks cycles 1..ncyc against per-cycle bit masks; ends in cycle ncyc+1.
   task automatic expect_cycles(input string tag, input int ncyc, input logic [31:0] ep,
                                input logic [31:0] eb, input logic [31:0] ed);
      for (int c = 1; c <= ncyc; c++) begin
         check($sformatf("%s.pulse@%0d", tag, c), 32'(bus.pulse_out), 32'(ep[c]));
         check($sformatf("%s.busy@%0d", tag, c), 32'(bus.busy), 32'(eb[c]));
         check($sformatf("%s.done@%0d", tag, c), 32'(bus.done), 32'(ed[c]));
         tick();
      end
   endtask

   // Counts busy/high cycles until done; stays in the done cycle. dc=-1 on timeout.
   task automatic measure(input int bound, output int nb, output int nh, output int dc);
      nb = 0;
      nh = 0;
      dc = -1;
      for (int c = 1; c <= bound; c++) begin
         if (bus.done) begin
            dc = c;
            break;
         end
         if (bus.busy) nb++;
         if (bus.pulse_out) nh++;
         tick();
      end
   endtask

   initial begin
      int          nb, nh, dc, nstrobe;
      logic [31:0] strobe_mask;
      logic [31:0] loop_pulse_mask;
      n_tests = 0;
      n_fail  = 0;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.high_cycles = '0;
      bus.low_cycles  = '0;
      bus.pulse_count = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst.pulse", 32'(bus.pulse_out), 32'd0);
      check("rst.busy", 32'(bus.busy), 32'd0);
      check("rst.done", 32'(bus.done), 32'd0);
      check("rst.sent", 32'(bus.pulses_sent), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Basic: high 1-2, 6-7, 11-12; busy 1-12; done 13.
      launch(16'd2, 16'd3, 16'd3);
      check("basic.sent@1", 32'(bus.pulses_sent), 32'd1);
      expect_cycles("basic", 14, 32'h0000_18C6, 32'h0000_1FFE, 32'h0000_2000);
      check("basic.sent", 32'(bus.pulses_sent), 32'd3);

      // Zero high/low behave as one cycle: high 1, low 2, high 3, done 4.
      launch(16'd0, 16'd0, 16'd2);
      expect_cycles("zero", 5, 32'h0000_000A, 32'h0000_000E, 32'h0000_0010);
      check("zero.sent", 32'(bus.pulses_sent), 32'd2);

      // N=0: done in cycle 1 only, sent cleared.
      launch(16'd5, 16'd5, 16'd0);
      expect_cycles("n0", 3, 32'h0, 32'h0, 32'h0000_0002);
      check("n0.sent", 32'(bus.pulses_sent), 32'd0);

      // Start during busy must not perturb the running train.
      launch(16'd2, 16'd3, 16'd3);
      tick();
      tick();
      bus.start       = 1'b1;
      bus.high_cycles = 16'd7;
      bus.low_cycles  = 16'd7;
      bus.pulse_count = 16'd9;
      tick();
      bus.start = 1'b0;
      measure(40, nb, nh, dc);
      check("busystart.busy_n", 32'(nb), 32'd9);
      check("busystart.high_n", 32'(nh), 32'd4);
      check("busystart.done_at", 32'(dc), 32'd10);
      check("busystart.sent", 32'(bus.pulses_sent), 32'd3);
      tick();

      // Abort in cycle 7 of a H=4 L=4 N=5 train.
      launch(16'd4, 16'd4, 16'd5);
      for (int i = 0; i < 6; i++) tick();
      check("abort.busy@7", 32'(bus.busy), 32'd1);
      check("abort.pulse@7", 32'(bus.pulse_out), 32'd0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort.pulse@8", 32'(bus.pulse_out), 32'd0);
      check("abort.busy@8", 32'(bus.busy), 32'd0);
      check("abort.done@8", 32'(bus.done), 32'd0);
      check("abort.sent@8", 32'(bus.pulses_sent), 32'd1);
      tick();
      check("abort.done@9", 32'(bus.done), 32'd0);
      check("abort.busy@9", 32'(bus.busy), 32'd0);
      launch(16'd4, 16'd4, 16'd5);
      measure(60, nb, nh, dc);
      check("full.busy_n", 32'(nb), 32'd36);
      check("full.high_n", 32'(nh), 32'd20);
      check("full.done_at", 32'(dc), 32'd37);
      check("full.sent", 32'(bus.pulses_sent), 32'd5);
      tick();

      // Abort while high, then abort+start together in IDLE.
      launch(16'd3, 16'd3, 16'd2);
      tick();
      check("abhigh.pulse@2", 32'(bus.pulse_out), 32'd1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abhigh.pulse", 32'(bus.pulse_out), 32'd0);
      check("abhigh.busy", 32'(bus.busy), 32'd0);
      check("abhigh.done", 32'(bus.done), 32'd0);
      check("abhigh.sent", 32'(bus.pulses_sent), 32'd1);
      bus.abort = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.abort = 1'b0;
      bus.start = 1'b0;
      check("abstart.busy", 32'(bus.busy), 32'd0);
      check("abstart.pulse", 32'(bus.pulse_out), 32'd0);
      check("abstart.done", 32'(bus.done), 32'd0);
      check("abstart.sent", 32'(bus.pulses_sent), 32'd1);
      tick();
      check("abstart.busy2", 32'(bus.busy), 32'd0);

      // Start in the done cycle of a H=1 L=1 N=1 train is accepted.
      launch(16'd1, 16'd1, 16'd1);
      measure(10, nb, nh, dc);
      check("donestart.done_at", 32'(dc), 32'd2);
      launch(16'd1, 16'd1, 16'd1);
      check("donestart.pulse", 32'(bus.pulse_out), 32'd1);
      check("donestart.busy", 32'(bus.busy), 32'd1);
      check("donestart.done", 32'(bus.done), 32'd0);
      tick();
      check("donestart.done2", 32'(bus.done), 32'd1);
      check("donestart.busy2", 32'(bus.busy), 32'd0);
      tick();

      // Asynchronous reset mid-HIGH, away from any clock edge.
      launch(16'd3, 16'd3, 16'd2);
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst.pulse", 32'(bus.pulse_out), 32'd0);
      check("arst.busy", 32'(bus.busy), 32'd0);
      check("arst.done", 32'(bus.done), 32'd0);
      check("arst.sent", 32'(bus.pulses_sent), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("arst.done_after", 32'(bus.done), 32'd0);
      check("arst.busy_after", 32'(bus.busy), 32'd0);
      tick();
      check("arst.done_after2", 32'(bus.done), 32'd0);
      check("arst.pulse_after2", 32'(bus.pulse_out), 32'd0);

      // Loopback into the edge detector: pulses 1,3,5,7 -> strobes 2,4,6,8.
      strobe_mask     = 32'h0000_0154;
      loop_pulse_mask = 32'h0000_00AA;
      nstrobe = 0;
      launch(16'd1, 16'd1, 16'd4);
      for (int c = 1; c <= 10; c++) begin
         check($sformatf("loop.pulse@%0d", c), 32'(bus.pulse_out), 32'(loop_pulse_mask[c]));
         check($sformatf("loop.strobe@%0d", c), 32'(det_strobe), 32'(strobe_mask[c]));
         if (det_strobe) nstrobe++;
         tick();
      end
      check("loop.strobes", 32'(nstrobe), 32'd4);
      check("loop.sent", 32'(bus.pulses_sent), 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
